// File: rtl/seg_mux_decoder.sv
// Receive-side decoder for the multiplexed seven-segment scoreboard bus.
// Each team has its own channel: sync, stability filter, digit capture, BCD-to-binary converter.

module seg_mux_channel #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_seg,
    input  logic [3:0]  i_ctrl,
    output logic [15:0] o_bcd,
    output logic [13:0] o_score,
    output logic        o_update,
    output logic        o_err_c
);
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned SCORE_W  = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [SAMPLE_W-1:0] r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_mask;
    logic [15:0]         r_stage;
    logic                r_full;
    logic [15:0]         r_pend;
    logic                r_pend_vld;
    logic [15:0]         r_conv_bcd;
    logic [15:0]         r_shift;
    logic [SCORE_W-1:0]  r_acc;
    logic [1:0]          r_step;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic                w_diff, w_accept;
    logic                w_slot_vld, w_legal, w_cap, w_err;
    logic [1:0]          w_slot;
    logic [3:0]          w_slot_oh;
    logic [3:0]          w_digit;
    logic                w_start;
    logic [15:0]         w_src;
    logic [SCORE_W-1:0]  w_acc_next;

    // Accept once, on the edge the stable count climbs to its ceiling
    assign w_diff   = (r_sync2 != r_prev);
    assign w_accept = !w_diff && (r_cnt == CNT_MAX - CNT_W'(1));

    always_comb begin
        w_slot_vld = 1'b0;
        w_slot     = 2'd0;
        w_slot_oh  = 4'b0000;
        case (r_sync2[11:8])
            4'b1110: begin w_slot_vld = 1'b1; w_slot = 2'd0; w_slot_oh = 4'b0001; end
            4'b1101: begin w_slot_vld = 1'b1; w_slot = 2'd1; w_slot_oh = 4'b0010; end
            4'b1011: begin w_slot_vld = 1'b1; w_slot = 2'd2; w_slot_oh = 4'b0100; end
            4'b0111: begin w_slot_vld = 1'b1; w_slot = 2'd3; w_slot_oh = 4'b1000; end
            default: ;
        endcase
    end

    // Segment pattern {A..G}, active-low; DP is not part of the digit
    always_comb begin
        w_digit = 4'd0;
        w_legal = 1'b1;
        case (r_sync2[7:1])
            7'b0000001: w_digit = 4'd0;
            7'b1001111: w_digit = 4'd1;
            7'b0010010: w_digit = 4'd2;
            7'b0000110: w_digit = 4'd3;
            7'b1001100: w_digit = 4'd4;
            7'b0100100: w_digit = 4'd5;
            7'b0100000: w_digit = 4'd6;
            7'b0001111: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0000100: w_digit = 4'd9;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_cap   = w_accept && w_slot_vld && w_legal;
    assign w_err   = w_accept && w_slot_vld && !w_legal;
    assign o_err_c = w_err;

    // A freshly completed frame beats an older pending one
    assign w_start    = (r_state == ST_IDLE) && (r_full || r_pend_vld);
    assign w_src      = r_full ? r_stage : r_pend;
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + SCORE_W'(r_shift[15:12]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_CONV;
            ST_CONV: if (r_step == 2'd3) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_stage    <= '0;
            r_full     <= 1'b0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_conv_bcd <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_step     <= '0;
            o_bcd      <= '0;
            o_score    <= '0;
            o_update   <= 1'b0;
        end else begin
            r_sync1 <= {i_ctrl, i_seg};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_diff)                r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);

            r_full <= w_cap && ((r_mask | w_slot_oh) == 4'hF);
            if (w_cap) r_stage[{w_slot, 2'b00} +: 4] <= w_digit;

            if (w_err)       r_mask <= '0;
            else if (w_cap)  r_mask <= r_mask | w_slot_oh;
            else if (r_full) r_mask <= '0;

            // Frame completed while the converter is busy: park it
            if (r_full && (r_state != ST_IDLE)) begin
                r_pend     <= r_stage;
                r_pend_vld <= 1'b1;
            end else if (w_start) begin
                r_pend_vld <= 1'b0;
            end

            o_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_conv_bcd <= w_src;
                        r_shift    <= w_src;
                        r_acc      <= '0;
                        r_step     <= '0;
                    end
                end
                ST_CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 4;
                    r_step  <= r_step + 2'd1;
                end
                ST_DONE: begin
                    o_bcd    <= r_conv_bcd;
                    o_score  <= r_acc;
                    o_update <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

module seg_mux_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg1,
    input  logic [7:0]  seg2,
    input  logic [3:0]  ctrl1,
    input  logic [3:0]  ctrl2,
    output logic [15:0] team1_bcd,
    output logic [15:0] team2_bcd,
    output logic [13:0] team1_score,
    output logic [13:0] team2_score,
    output logic        team1_update,
    output logic        team2_update,
    output logic        decode_err
);
    logic w_err1_c, w_err2_c;

    seg_mux_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_team1 (
        .clk      (clk),
        .reset    (reset),
        .i_seg    (seg1),
        .i_ctrl   (ctrl1),
        .o_bcd    (team1_bcd),
        .o_score  (team1_score),
        .o_update (team1_update),
        .o_err_c  (w_err1_c)
    );

    seg_mux_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_team2 (
        .clk      (clk),
        .reset    (reset),
        .i_seg    (seg2),
        .i_ctrl   (ctrl2),
        .o_bcd    (team2_bcd),
        .o_score  (team2_score),
        .o_update (team2_update),
        .o_err_c  (w_err2_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) decode_err <= 1'b0;
        else       decode_err <= w_err1_c | w_err2_c;
    end
endmodule

// File: tb/tb_seg_mux_decoder.sv
// Bench for seg_mux_decoder: per-edge input waveforms, an event-level reference model,
// frame vector table, directed corner sequences and a randomized run.

module tb_seg_mux_decoder;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  seg1, seg2;
    logic [3:0]  ctrl1, ctrl2;
    logic [15:0] team1_bcd, team2_bcd;
    logic [13:0] team1_score, team2_score;
    logic        team1_update, team2_update, decode_err;

    seg_mux_decoder #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .seg1         (seg1),
        .seg2         (seg2),
        .ctrl1        (ctrl1),
        .ctrl2        (ctrl2),
        .team1_bcd    (team1_bcd),
        .team2_bcd    (team2_bcd),
        .team1_score  (team1_score),
        .team2_score  (team2_score),
        .team1_update (team1_update),
        .team2_update (team2_update),
        .decode_err   (decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t1;
        logic [15:0] t2;
        int          score1;
        int          score2;
    } frame_vec_t;

    frame_vec_t  vecs[6];
    logic [11:0] w1[$], w2[$];
    logic [15:0] eu1[int], eu2[int];
    bit          ee[int];
    int          n_vec = 0, n_err = 0;
    logic [15:0] cur1, cur2;
    int          first_upd1, first_upd2, n_upd1, n_upd2, n_derr;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int dec(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (pat(d) == p) return d;
        return -1;
    endfunction

    function automatic int bin(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, c, got, exp);
        end
    endtask

    task automatic push(input int team, input logic [11:0] v, input int n);
        repeat (n) begin
            if (team == 1) w1.push_back(v);
            else           w2.push_back(v);
        end
    endtask

    task automatic add_idle(input int team, input int n);
        push(team, 12'hFFF, n);
    endtask

    task automatic add_digit(input int team, input int slot, input int d, input logic dp, input int n);
        logic [3:0] c;
        c = ~(4'b0001 << slot);
        push(team, {c, pat(d), dp}, n);
    endtask

    // Slots sent ones first, thousands last
    task automatic add_frame(input int team, input logic [15:0] b, input int n);
        for (int s = 0; s < 4; s++) add_digit(team, s, int'(b[s*4 +: 4]), 1'b1, n);
    endtask

    task automatic equalize();
        while (w1.size() < w2.size()) w1.push_back(12'hFFF);
        while (w2.size() < w1.size()) w2.push_back(12'hFFF);
        repeat (40) begin
            w1.push_back(12'hFFF);
            w2.push_back(12'hFFF);
        end
    endtask

    task automatic clear_waves();
        w1.delete();
        w2.delete();
    endtask

    task automatic add_random(input int team, input int len);
        int sz;
        logic [3:0] c;
        logic [7:0] sg;
        int h;
        sz = 0;
        while (sz < len) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 80)      c = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 90) c = 4'hF;
            else             c = 4'($urandom);
            if ($urandom_range(0, 9) != 0) sg = {pat(int'($urandom_range(0, 9))), 1'($urandom)};
            else                           sg = 8'($urandom);
            if ($urandom_range(0, 3) == 0) h = int'($urandom_range(1, S - 1));
            else                           h = int'($urandom_range(S + 2, 14));
            push(team, {c, sg}, h);
            sz += h;
        end
    endtask

    // Reference: a value held on the inputs for edges E..E+S is accepted at E+2+S;
    // a completed frame starts converting the next free edge and updates 5 edges later.
    task automatic model_team(input int team);
        logic [11:0] w[$];
        int          acc_t[$];
        logic [11:0] acc_v[$];
        int          cmp_t[$];
        logic [15:0] cmp_v[$];
        logic [3:0]  mask;
        logic [15:0] stg;
        logic [11:0] v;
        int          nf, s, i, slot, d;
        if (team == 1) w = w1;
        else           w = w2;
        for (int c = 0; c < w.size(); c++) begin
            if (c == 0 || w[c] != w[c-1]) begin
                bit stable;
                stable = (c + S < w.size());
                for (int k = 1; k <= S; k++) if (stable && w[c+k] != w[c]) stable = 0;
                if (stable) begin
                    acc_t.push_back(c + 2 + S);
                    acc_v.push_back(w[c]);
                end
            end
        end
        mask = '0;
        stg  = '0;
        for (int a = 0; a < acc_t.size(); a++) begin
            v = acc_v[a];
            slot = -1;
            for (int k = 0; k < 4; k++) if (v[11:8] == ~(4'b0001 << k)) slot = k;
            if (slot >= 0) begin
                d = dec(v[7:1]);
                if (d < 0) begin
                    ee[acc_t[a]] = 1'b1;
                    mask = '0;
                end else begin
                    stg[slot*4 +: 4] = 4'(d);
                    mask[slot] = 1'b1;
                    if (mask == 4'hF) begin
                        cmp_t.push_back(acc_t[a]);
                        cmp_v.push_back(stg);
                        mask = '0;
                    end
                end
            end
        end
        nf = 0;
        i  = 0;
        while (i < cmp_t.size()) begin
            s = cmp_t[i] + 1;
            if (s < nf) s = nf;
            while (i + 1 < cmp_t.size() && cmp_t[i+1] + 1 <= s) i++;
            if (team == 1) eu1[s + 5] = cmp_v[i];
            else           eu2[s + 5] = cmp_v[i];
            nf = s + 6;
            i++;
        end
    endtask

    task automatic rst_chk(input string tag, input int c);
        chk({tag, "_bcd1"}, c, 32'(team1_bcd), 32'd0);
        chk({tag, "_bcd2"}, c, 32'(team2_bcd), 32'd0);
        chk({tag, "_score1"}, c, 32'(team1_score), 32'd0);
        chk({tag, "_score2"}, c, 32'(team2_score), 32'd0);
        chk({tag, "_upd1"}, c, 32'(team1_update), 32'd0);
        chk({tag, "_upd2"}, c, 32'(team2_update), 32'd0);
        chk({tag, "_derr"}, c, 32'(decode_err), 32'd0);
    endtask

    task automatic monitor(input int c);
        if (eu1.exists(c)) cur1 = eu1[c];
        if (eu2.exists(c)) cur2 = eu2[c];
        chk("team1_update", c, 32'(team1_update), 32'(eu1.exists(c)));
        chk("team1_bcd", c, 32'(team1_bcd), 32'(cur1));
        chk("team1_score", c, 32'(team1_score), 32'(bin(cur1)));
        chk("team2_update", c, 32'(team2_update), 32'(eu2.exists(c)));
        chk("team2_bcd", c, 32'(team2_bcd), 32'(cur2));
        chk("team2_score", c, 32'(team2_score), 32'(bin(cur2)));
        chk("decode_err", c, 32'(decode_err), 32'(ee.exists(c)));
        if (team1_update) begin n_upd1++; if (first_upd1 < 0) first_upd1 = c; end
        if (team2_update) begin n_upd2++; if (first_upd2 < 0) first_upd2 = c; end
        if (decode_err) n_derr++;
    endtask

    // Reset, then play both waveforms edge by edge (cut < 0 plays all of it)
    task automatic run(input int cut);
        int n;
        eu1.delete(); eu2.delete(); ee.delete();
        model_team(1);
        model_team(2);
        n = (cut < 0) ? w1.size() : cut;
        @(negedge clk);
        reset = 1'b1;
        {ctrl1, seg1} = 12'hFFF;
        {ctrl2, seg2} = 12'hFFF;
        #1;
        rst_chk("reset", 0);
        cur1 = '0; cur2 = '0;
        first_upd1 = -1; first_upd2 = -1;
        n_upd1 = 0; n_upd2 = 0; n_derr = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            {ctrl1, seg1} = w1[c];
            {ctrl2, seg2} = w2[c];
            @(posedge clk);
            #1;
            monitor(c);
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        reset = 1'b1;
        {ctrl1, seg1} = 12'hFFF;
        {ctrl2, seg2} = 12'hFFF;
        vecs[0] = '{16'h1234, 16'h0000, 1234, 0};
        vecs[1] = '{16'h5678, 16'h0042, 5678, 42};
        vecs[2] = '{16'h9999, 16'h9999, 9999, 9999};
        vecs[3] = '{16'h0000, 16'h0001, 0, 1};
        vecs[4] = '{16'h1000, 16'h0909, 1000, 909};
        vecs[5] = '{16'h4321, 16'h8765, 4321, 8765};

        foreach (vecs[i]) begin
            clear_waves();
            add_idle(1, 8); add_idle(2, 8);
            add_frame(1, vecs[i].t1, 10);
            add_frame(2, vecs[i].t2, 10);
            equalize();
            run(-1);
            chk("tbl_bcd1", i, 32'(team1_bcd), 32'(vecs[i].t1));
            chk("tbl_score1", i, 32'(team1_score), 32'(vecs[i].score1));
            chk("tbl_bcd2", i, 32'(team2_bcd), 32'(vecs[i].t2));
            chk("tbl_score2", i, 32'(team2_score), 32'(vecs[i].score2));
        end

        // Frame 1234 with 16-cycle slots; thousands slot begins at edge 56
        clear_waves();
        add_idle(1, 8); add_frame(1, 16'h1234, 16); add_idle(2, 8);
        equalize();
        run(-1);
        chk("f1234_update_edge", 0, 32'(first_upd1), 32'(56 + 2 + S + 6));
        chk("f1234_update_count", 0, 32'(n_upd1), 32'd1);
        chk("f1234_t2_updates", 0, 32'(n_upd2), 32'd0);

        // Thousands select held 64 cycles while team 2 sends 9999
        clear_waves();
        add_idle(1, 8);
        add_digit(1, 3, 3, 1'b1, 64);
        add_digit(1, 0, 1, 1'b1, 16);
        add_digit(1, 1, 2, 1'b1, 16);
        add_digit(1, 2, 4, 1'b1, 16);
        add_idle(2, 8); add_frame(2, 16'h9999, 16);
        equalize();
        run(-1);
        chk("held_t1_updates", 0, 32'(n_upd1), 32'd1);
        chk("held_t1_bcd", 0, 32'(team1_bcd), 32'h3421);
        chk("held_t2_score", 0, 32'(team2_score), 32'd9999);
        chk("held_t2_updates", 0, 32'(n_upd2), 32'd1);

        // Three-cycle "8" glitch inside a held "0" slot
        clear_waves();
        add_idle(1, 8); add_frame(1, 16'h1234, 12);
        add_digit(1, 0, 0, 1'b1, 6);
        add_digit(1, 0, 8, 1'b1, 3);
        add_digit(1, 0, 0, 1'b1, 7);
        add_digit(1, 1, 0, 1'b1, 16);
        add_digit(1, 2, 0, 1'b1, 16);
        add_digit(1, 3, 0, 1'b1, 16);
        equalize();
        run(-1);
        chk("glitch_updates", 0, 32'(n_upd1), 32'd2);
        chk("glitch_bcd", 0, 32'(team1_bcd), 32'h0000);

        // Blank pattern in the tens slot mid-frame
        clear_waves();
        add_idle(1, 8); add_frame(1, 16'h1234, 12);
        add_digit(1, 0, 5, 1'b1, 12);
        push(1, {4'b1101, 8'hFF}, 12);
        add_frame(1, 16'h9876, 12);
        equalize();
        run(-1);
        chk("err_pulses", 0, 32'(n_derr), 32'd1);
        chk("err_updates", 0, 32'(n_upd1), 32'd2);
        chk("err_bcd", 0, 32'(team1_bcd), 32'h9876);

        // Both teams complete on the same edge; DP toggles in the ones slot
        clear_waves();
        add_idle(1, 8); add_idle(2, 8);
        add_digit(1, 0, 8, 1'b1, 8); add_digit(1, 0, 8, 1'b0, 8);
        add_digit(1, 1, 7, 1'b1, 16); add_digit(1, 2, 6, 1'b1, 16); add_digit(1, 3, 5, 1'b1, 16);
        add_digit(2, 0, 2, 1'b1, 8); add_digit(2, 0, 2, 1'b0, 8);
        add_digit(2, 1, 4, 1'b1, 16); add_digit(2, 2, 0, 1'b1, 16); add_digit(2, 3, 0, 1'b1, 16);
        equalize();
        run(-1);
        chk("sim_t1_edge", 0, 32'(first_upd1), 32'(8 + 16 + 32 + 2 + S + 6));
        chk("sim_t2_edge", 0, 32'(first_upd2), 32'(8 + 16 + 32 + 2 + S + 6));
        chk("sim_score1", 0, 32'(team1_score), 32'd5678);
        chk("sim_score2", 0, 32'(team2_score), 32'd42);

        // Reset while the second frame is converting
        clear_waves();
        add_idle(1, 8); add_frame(1, 16'h1111, 12);
        add_idle(1, 10); add_frame(1, 16'h1234, 12);
        equalize();
        eu1.delete(); ee.delete();
        model_team(1);
        void'(eu1.last(k));
        run(k - 3);
        chk("midconv_prev_bcd", 0, 32'(team1_bcd), 32'h1111);
        reset = 1'b1;
        #1;
        rst_chk("midconv", 0);
        clear_waves();
        add_idle(1, 8); add_frame(1, 16'h2468, 12);
        equalize();
        run(-1);
        chk("post_reset_bcd", 0, 32'(team1_bcd), 32'h2468);
        chk("post_reset_updates", 0, 32'(n_upd1), 32'd1);

        // Randomized traffic on both teams
        clear_waves();
        add_idle(1, 8); add_idle(2, 8);
        add_random(1, 1500);
        add_random(2, 1500);
        equalize();
        run(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
